// File: rtl/m_bcd_updown_counter_pkg.sv
// +-----------------------------------------------------------------------------+
// | m_bcd_updown_counter_pkg : shared BCD constants, op decode and helpers       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package m_bcd_updown_counter_pkg;

   localparam int BCD_DIGIT_W    = 4;
   localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
   localparam int BCD_MAX_DIGITS = 8;

   // Per-edge operation after applying clr > load > en priority.
   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_COUNT = 2'd1,
      OP_LOAD  = 2'd2,
      OP_CLR   = 2'd3
   } bcd_op_e;

   function automatic logic [BCD_MAX_DIGITS*BCD_DIGIT_W-1:0] bcd_max(input int digits);
      logic [BCD_MAX_DIGITS*BCD_DIGIT_W-1:0] r;
      r = '0;
      for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
         if (i < digits) begin
            r[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_MAX_DIGIT;
         end
      end
      return r;
   endfunction

   function automatic logic bcd_digit_bad(input logic [BCD_DIGIT_W-1:0] d);
      return (d > BCD_MAX_DIGIT);
   endfunction

   function automatic logic [BCD_DIGIT_W-1:0] bcd_sanitize(input logic [BCD_DIGIT_W-1:0] d);
      return bcd_digit_bad(d) ? BCD_MAX_DIGIT : d;
   endfunction

   function automatic bcd_op_e bcd_decode_op(input logic clr, input logic load, input logic en);
      bcd_op_e op;
      if (clr) begin
         op = OP_CLR;
      end else if (load) begin
         op = OP_LOAD;
      end else if (en) begin
         op = OP_COUNT;
      end else begin
         op = OP_HOLD;
      end
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/m_bcd_updown_counter_digit.sv
// +-----------------------------------------------------------------------------+
// | m_bcd_digit : single BCD digit up/down cell with clear, load and step        |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module m_bcd_digit
   import m_bcd_updown_counter_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   step,
   input  logic                   up,
   input  logic                   load,
   input  logic                   clr,
   input  logic [BCD_DIGIT_W-1:0] load_digit,
   output logic [BCD_DIGIT_W-1:0] digit,
   output logic                   at_top,
   output logic                   at_bottom
);

   logic [BCD_DIGIT_W-1:0] r_digit;
   logic [BCD_DIGIT_W-1:0] w_next;

   assign at_top    = (r_digit == BCD_MAX_DIGIT);
   assign at_bottom = (r_digit == '0);
   assign digit     = r_digit;

   always_comb begin
      w_next = r_digit;
      if (clr) begin
         w_next = '0;
      end else if (load) begin
         // Sanitised here as well so the cell can never hold a non-BCD value.
         w_next = bcd_sanitize(load_digit);
      end else if (step) begin
         if (up) begin
            w_next = at_top ? '0 : r_digit + 4'd1;
         end else begin
            w_next = at_bottom ? BCD_MAX_DIGIT : r_digit - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_digit <= '0;
      end else begin
         r_digit <= w_next;
      end
   end

endmodule

`default_nettype wire

// File: rtl/m_bcd_updown_counter.sv
// +-----------------------------------------------------------------------------+
// | m_bcd_updown_counter : parametrised multi-digit BCD up/down counter with     |
// | wrap/saturate limits, parallel load and overflow/underflow pulses            |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module m_bcd_updown_counter
   import m_bcd_updown_counter_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter bit          WRAP   = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      up,
   input  logic                      clr,
   input  logic                      load,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] load_val,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
   output logic                      tc,
   output logic                      ovf,
   output logic                      udf,
   output logic                      load_err
);

   localparam int W = BCD_DIGIT_W * DIGITS;
   localparam logic [BCD_MAX_DIGITS*BCD_DIGIT_W-1:0] c_MAX_FULL = bcd_max(DIGITS);
   localparam logic [W-1:0] c_MAX = c_MAX_FULL[W-1:0];

   bcd_op_e           w_op;
   logic [DIGITS-1:0] w_at_top;
   logic [DIGITS-1:0] w_at_bottom;
   logic [DIGITS-1:0] w_step;
   logic [DIGITS-1:0] w_digit_bad;
   logic              w_at_max;
   logic              w_at_zero;
   logic              w_at_limit;
   logic              w_count;
   logic              w_clr;
   logic              w_load;

   logic r_ovf;
   logic r_udf;
   logic r_load_err;

   assign w_op       = bcd_decode_op(clr, load, en);
   assign w_clr      = (w_op == OP_CLR);
   assign w_load     = (w_op == OP_LOAD);
   assign w_at_max   = &w_at_top;
   assign w_at_zero  = &w_at_bottom;
   assign w_at_limit = up ? w_at_max : w_at_zero;

   // Saturating instances freeze every digit at the limit instead of rolling over.
   assign w_count = (w_op == OP_COUNT) & ~(~WRAP & w_at_limit);

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         if (gi == 0) begin : g_lsd
            assign w_step[gi] = w_count;
         end else begin : g_upper
            // Prefix-AND of lower digits rather than a bit-to-bit ripple on w_step.
            assign w_step[gi] = w_count &
                                (up ? (&w_at_top[gi-1:0]) : (&w_at_bottom[gi-1:0]));
         end

         assign w_digit_bad[gi] = bcd_digit_bad(load_val[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);

         m_bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .step       (w_step[gi]),
            .up         (up),
            .load       (w_load),
            .clr        (w_clr),
            .load_digit (load_val[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit      (bcd_out[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .at_top     (w_at_top[gi]),
            .at_bottom  (w_at_bottom[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ovf      <= 1'b0;
         r_udf      <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_ovf      <= (w_op == OP_COUNT) &  up & w_at_max;
         r_udf      <= (w_op == OP_COUNT) & ~up & w_at_zero;
         r_load_err <= w_load & (|w_digit_bad);
      end
   end

   assign ovf      = r_ovf;
   assign udf      = r_udf;
   assign load_err = r_load_err;
   assign tc       = up ? (bcd_out == c_MAX) : (bcd_out == '0);

endmodule

`default_nettype wire

// File: doc/m_bcd_updown_counter.md
Name: m_bcd_updown_counter

Overview:
Parametrised multi-digit BCD counter. It is the successor to the fixed 2-digit up-only BCD counter.
- Adds up/down counting, count enable, synchronous clear, parallel load with digit sanitising, and a wrap or saturate mode.
- Provides registered overflow/underflow pulses and a combinational terminal-count output.
- Feeds the 7-segment display path (one 4-bit digit per segment decoder) and serves as an event/timer counter elsewhere in the kit.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count width = 4*DIGITS.
- WRAP, 1, 1 = wrap at the limits, 0 = saturate at the limits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per clk while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clr  input  1  synchronous clear to zero.
- load  input  1  synchronous parallel load.
- load_val  input  4*DIGITS  BCD value to load; digit i = bits [4i+3:4i].
- bcd_out  output  4*DIGITS  current count, registered.
- tc  output  1  terminal count, combinational.
- ovf  output  1  overflow pulse, registered.
- udf  output  1  underflow pulse, registered.
- load_err  output  1  pulse: the loaded value contained a non-BCD digit.

Behaviour:
- Reset (async, reset=1):
  - bcd_out = 0, ovf = 0, udf = 0, load_err = 0 immediately.
  - Held while reset is high; counting resumes on the first clk edge after release.
- Priority per clk edge: clr > load > en. Inputs not selected are ignored that cycle.
- clr=1: bcd_out <= 0. ovf, udf and load_err are 0 that cycle.
- load=1:
  - Each digit of load_val greater than 9 is replaced by 9; other digits load unchanged.
  - load_err <= 1 for exactly one cycle if any digit was replaced, else 0.
  - ovf <= 0, udf <= 0.
- en=1 and up=1:
  - Digit 0 increments.
  - Digit i (i>0) steps only when every lower digit equals 9. It steps in the same cycle (ripple-carry chain, single-cycle latency).
  - A digit at 9 that steps goes to 0.
- en=1 and up=0:
  - Digit 0 decrements.
  - Digit i (i>0) steps only when every lower digit equals 0.
  - A digit at 0 that steps goes to 9.
- Limit handling, up at MAX (all digits 9):
  - WRAP=1: bcd_out <= 0, ovf <= 1 for one cycle.
  - WRAP=0: bcd_out holds MAX; ovf <= 1 on every enabled cycle spent at the limit.
- Limit handling, down at 0:
  - WRAP=1: bcd_out <= MAX, udf <= 1 for one cycle.
  - WRAP=0: bcd_out holds 0; udf <= 1 on every enabled cycle.
- ovf, udf and load_err are otherwise 0 each cycle; they never stay high without a fresh cause.
- tc = (up & bcd_out==MAX) | (~up & bcd_out==0). It is asserted regardless of en, for cascading external counters.
- Direction change mid-count takes effect on the next enabled edge, with no extra step.
- en=0: count holds, and ovf/udf go to 0.
- Invariant: bcd_out never contains a digit greater than 9, from any input sequence.

Decomposition:
- Shared package holds:
  - BCD_DIGIT_W = 4;
  - BCD_MAX_DIGIT = 4'd9;
  - a function returning the all-nines MAX value for a given DIGITS.
- One sub-module, m_bcd_digit: a single-digit up/down cell.
  - Inputs: step, up, load, clr, load digit.
  - Outputs: digit, plus combinational at_top (==9) and at_bottom (==0).
  - The top level instantiates DIGITS copies with a generate loop and builds the carry/borrow enable chain from the at_top/at_bottom outputs.

Test Plan:
- DIGITS=4, WRAP=1; reset, en=1, up=1, 1100 cycles -> bcd_out passes 0009 -> 0010, 0099 -> 0100, reaches 1100; no ovf; tc never asserted.
- Load 9998, up=1, en=1 -> 9999 with tc=1 -> 0000 with ovf=1 for one cycle -> 0001 with ovf=0.
- Load 0001, up=0 -> 0000 with tc=1 -> 9999 with udf=1 for one cycle; WRAP=0 instance instead holds 0000 with udf=1 every enabled cycle.
- Load 12F4 (digit 1 = 0xF) -> bcd_out=1294, load_err=1 for one cycle; load 00A0 with clr=1 in the same cycle -> bcd_out=0000, load_err=0.
- Count up to 0457, assert reset between clk edges -> bcd_out=0000 before the next edge; release -> 0001 on the first enabled edge after release.
- Random en/up/load/clr for 10k cycles against a decimal reference model -> exact match; no digit ever exceeds 9.
